// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared pipeline constants for the register file and writeback path.
// Rev    : 1.0
// ============================================================================
package riscv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_AW    = 5;

    localparam int REG_ZERO = 0;

    // Writeback select encoding for "result comes from data memory".
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : reg_scoreboard
// Brief  : Per-register pending-load bits and the decode operand stall check.
// Rev    : 1.0
// ============================================================================
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [AW-1:0] rd_addr1,
    input  logic [AW-1:0] rd_addr2,
    output logic          stall
);

    localparam logic [AW:0]   NREGS_A = (AW+1)'(NREGS);
    localparam logic [AW-1:0] ZERO_A  = AW'(REG_ZERO);

    logic [NREGS-1:0] r_pending;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREGS_A;
    endfunction

    // Clear first, then set: a younger load to the same register must win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            if (wb_en && in_range(wb_addr))
                r_pending[wb_addr] <= 1'b0;
            if (load_en && load_addr != ZERO_A && in_range(load_addr))
                r_pending[load_addr] <= 1'b1;
        end
    end

    // A load already in W is not a hazard: the read bypass forwards its data.
    function automatic logic hit(input logic [AW-1:0] a);
        logic pend;
        pend = in_range(a) ? r_pending[a] : 1'b0;
        return (a != ZERO_A) &&
               ((load_en && load_addr == a) || (pend && !(wb_en && wb_addr == a)));
    endfunction

    always_comb begin
        stall = hit(rd_addr1) | hit(rd_addr2);
    end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile
// Brief  : Architectural register file with write-through read bypass and
//          load-use stall generation for the decode stage.
// Rev    : 1.0
// ============================================================================
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = DEF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWriteW,
    input  logic [AW-1:0]    RdW,
    input  logic [WIDTH-1:0] ResultW,
    input  logic             LoadE,
    input  logic [AW-1:0]    RdE,
    input  logic [AW-1:0]    A1D,
    input  logic [AW-1:0]    A2D,
    output logic [WIDTH-1:0] RD1D,
    output logic [WIDTH-1:0] RD2D,
    output logic             StallD
);

    localparam logic [AW:0]   NREGS_A = (AW+1)'(NREGS);
    localparam logic [AW-1:0] ZERO_A  = AW'(REG_ZERO);

    logic [WIDTH-1:0] r_regs [NREGS];
    logic [AW-1:0]    w_addr [2];
    logic [WIDTH-1:0] w_rd   [2];
    logic             w_wr_ok;

    assign w_wr_ok = RegWriteW && (RdW != ZERO_A) && ({1'b0, RdW} < NREGS_A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[RdW] <= ResultW;
        end
    end

    assign w_addr[0] = A1D;
    assign w_addr[1] = A2D;

    // x0 and out-of-range addresses read as zero, even when W targets them.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = '0;
            if (w_addr[p] != ZERO_A && {1'b0, w_addr[p]} < NREGS_A) begin
                if (RegWriteW && RdW == w_addr[p])
                    w_rd[p] = ResultW;
                else
                    w_rd[p] = r_regs[w_addr[p]];
            end
        end
    end

    assign RD1D = w_rd[0];
    assign RD2D = w_rd[1];

    reg_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_en     (RegWriteW),
        .wb_addr   (RdW),
        .load_en   (LoadE),
        .load_addr (RdE),
        .rd_addr1  (A1D),
        .rd_addr2  (A2D),
        .stall     (StallD)
    );

endmodule : wb_regfile
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_regfile
// Brief  : Self-checking bench for wb_regfile against an array/flag model.
// Rev    : 1.0
// ============================================================================
module tb_wb_regfile;

    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    logic             clk;
    logic             rst_n;
    logic             RegWriteW;
    logic [AW-1:0]    RdW;
    logic [WIDTH-1:0] ResultW;
    logic             LoadE;
    logic [AW-1:0]    RdE;
    logic [AW-1:0]    A1D;
    logic [AW-1:0]    A2D;
    logic [WIDTH-1:0] RD1D;
    logic [WIDTH-1:0] RD2D;
    logic             StallD;

    int n_checks = 0;
    int n_fail   = 0;

    wb_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .LoadE     (LoadE),
        .RdE       (RdE),
        .A1D       (A1D),
        .A2D       (A2D),
        .RD1D      (RD1D),
        .RD2D      (RD2D),
        .StallD    (StallD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: architectural values and "load still in flight" flags.
    logic [WIDTH-1:0] m_regs [NREGS];
    bit               m_pend [NREGS];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (RegWriteW && RdW != 0) m_regs[RdW] = ResultW;
            if (RegWriteW) m_pend[RdW] = 1'b0;
            if (LoadE && RdE != 0) m_pend[RdE] = 1'b1;
        end
    end

    function automatic logic [WIDTH-1:0] model_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (RegWriteW && RdW == a) return ResultW;
        return m_regs[a];
    endfunction

    function automatic logic model_hit(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        return (LoadE && RdE == a) || (m_pend[a] && !(RegWriteW && RdW == a));
    endfunction

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                            input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input int rdw, input logic [WIDTH-1:0] res,
                         input logic lde, input int rde, input int a1, input int a2);
        RegWriteW = we;
        RdW       = AW'(rdw);
        ResultW   = res;
        LoadE     = lde;
        RdE       = AW'(rde);
        A1D       = AW'(a1);
        A2D       = AW'(a2);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, '0, 0, 0, 5, 9);
        #1;
        check_eq("reset_rd1", RD1D, '0);
        check_eq("reset_rd2", RD2D, '0);
        check_eq("reset_stall", {31'b0, StallD}, 32'd0);
        #12;
        rst_n = 1'b1;
        next_cycle();

        // Write-through bypass, then retained value
        drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
        #1;
        check_eq("bypass_rd1", RD1D, 32'hDEADBEEF);
        next_cycle();
        drive(0, 0, '0, 0, 0, 5, 5);
        #1;
        check_eq("stored_rd1", RD1D, 32'hDEADBEEF);
        check_eq("stored_rd2", RD2D, 32'hDEADBEEF);

        // x0 is never written and never bypassed
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
        #1;
        check_eq("x0_bypass", RD2D, '0);
        next_cycle();
        drive(0, 0, '0, 0, 0, 0, 0);
        #1;
        check_eq("x0_read", RD2D, '0);

        // Load-use: two stall cycles, released by the W-stage bypass
        drive(0, 0, '0, 1, 7, 7, 0);
        #1;
        check_eq("lu_stall_e", {31'b0, StallD}, 32'd1);
        next_cycle();
        drive(0, 0, '0, 0, 0, 7, 0);
        #1;
        check_eq("lu_stall_m", {31'b0, StallD}, 32'd1);
        next_cycle();
        drive(1, 7, 32'h55, 0, 0, 7, 0);
        #1;
        check_eq("lu_stall_w", {31'b0, StallD}, 32'd0);
        check_eq("lu_rd_w", RD1D, 32'h55);
        next_cycle();
        drive(0, 0, '0, 0, 0, 7, 0);
        #1;
        check_eq("lu_cleared", {31'b0, StallD}, 32'd0);
        check_eq("lu_rd_after", RD1D, 32'h55);

        // Same-edge set and clear on one register: set wins
        drive(1, 9, 32'h99, 1, 9, 0, 0);
        next_cycle();
        drive(0, 0, '0, 0, 0, 9, 0);
        #1;
        check_eq("conflict_stall", {31'b0, StallD}, 32'd1);
        next_cycle();
        drive(1, 9, 32'h1234, 0, 0, 0, 9);
        #1;
        check_eq("conflict_release", {31'b0, StallD}, 32'd0);
        check_eq("conflict_rd2", RD2D, 32'h1234);
        next_cycle();

        // Unrelated operands do not stall
        drive(0, 0, '0, 1, 3, 4, 0);
        #1;
        check_eq("indep_stall", {31'b0, StallD}, 32'd0);
        next_cycle();

        // Asynchronous reset mid-run with pending load and stored data
        drive(0, 0, '0, 0, 0, 5, 3);
        #1;
        check_eq("pre_reset_rd1", RD1D, 32'hDEADBEEF);
        check_eq("pre_reset_stall", {31'b0, StallD}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_rd1", RD1D, '0);
        check_eq("async_rst_stall", {31'b0, StallD}, 32'd0);
        #2;
        rst_n = 1'b1;
        next_cycle();

        // Randomized regression; small address pool makes hazards frequent
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 11)), $urandom(),
                  1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 11)), int'($urandom_range(0, 11)));
            if ($urandom_range(0, 15) == 0) begin
                A1D = AW'($urandom_range(0, NREGS - 1));
                RdW = AW'($urandom_range(0, NREGS - 1));
            end
            #1;
            check_eq("rnd_rd1", RD1D, model_rd(A1D));
            check_eq("rnd_rd2", RD2D, model_rd(A2D));
            check_eq("rnd_stall", {31'b0, StallD}, {31'b0, model_hit(A1D) | model_hit(A2D)});
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wb_regfile
`default_nettype wire
